// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush handling
// and a saturating count of inserted load-use bubbles.
module id_ex_reg #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ValidD,
   input  logic            FlushE,
   input  logic [XLEN-1:0] PC_D,
   input  logic [XLEN-1:0] rs1_data_D,
   input  logic [XLEN-1:0] rs2_data_D,
   input  logic [XLEN-1:0] imm_ext_D,
   input  logic [4:0]      rs1_D,
   input  logic [4:0]      rs2_D,
   input  logic [4:0]      rd_D,
   input  logic            ALUSrc_D,
   input  logic            RegWrite_D,
   input  logic            MemWrite_D,
   input  logic            Branch_D,
   input  logic [2:0]      ALUControl_D,
   input  logic [1:0]      ResultSrc_D,
   output logic            ValidE,
   output logic [XLEN-1:0] PC_E,
   output logic [XLEN-1:0] rs1_data_E,
   output logic [XLEN-1:0] rs2_data_E,
   output logic [XLEN-1:0] imm_ext_E,
   output logic [4:0]      rs1_E,
   output logic [4:0]      rs2_E,
   output logic [4:0]      rd_E,
   output logic            ALUSrc_E,
   output logic            RegWrite_E,
   output logic            MemWrite_E,
   output logic            Branch_E,
   output logic [2:0]      ALUControl_E,
   output logic [1:0]      ResultSrc_E,
   output logic            StallF,
   output logic            StallD,
   output logic [15:0]     BubbleCnt
);

   localparam logic [1:0]  RESULT_LOAD = 2'b01;
   localparam logic [15:0] CNT_MAX     = 16'hFFFF;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm_ext;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            alu_src;
      logic            reg_write;
      logic            mem_write;
      logic            branch;
      logic [2:0]      alu_control;
      logic [1:0]      result_src;
   } ex_t;

   ex_t         ex_q, ex_d, id_in;
   logic [15:0] bubble_cnt_q, bubble_cnt_d;
   logic        load_use;

   assign id_in = '{valid: ValidD, pc: PC_D, rs1_data: rs1_data_D, rs2_data: rs2_data_D,
                    imm_ext: imm_ext_D, rs1: rs1_D, rs2: rs2_D, rd: rd_D,
                    alu_src: ALUSrc_D, reg_write: RegWrite_D, mem_write: MemWrite_D,
                    branch: Branch_D, alu_control: ALUControl_D, result_src: ResultSrc_D};

   // A load writing x0 never produces a value, so it cannot create a hazard.
   assign load_use = ex_q.valid && ex_q.reg_write && (ex_q.result_src == RESULT_LOAD) &&
                     (ex_q.rd != 5'd0) && ((ex_q.rd == rs1_D) || (ex_q.rd == rs2_D));

   assign StallF = load_use & ~FlushE;
   assign StallD = load_use & ~FlushE;

   always_comb begin
      // NOTE: every always_comb target is given a default first so no latch can be inferred.
      ex_d         = id_in;
      bubble_cnt_d = bubble_cnt_q;
      if (FlushE) begin
         ex_d = '0;
      end else if (load_use) begin
         ex_d = '0;
         if (bubble_cnt_q != CNT_MAX) bubble_cnt_d = bubble_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q         <= '0;
         bubble_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values together.
         ex_q         <= ex_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign ValidE       = ex_q.valid;
   assign PC_E         = ex_q.pc;
   assign rs1_data_E   = ex_q.rs1_data;
   assign rs2_data_E   = ex_q.rs2_data;
   assign imm_ext_E    = ex_q.imm_ext;
   assign rs1_E        = ex_q.rs1;
   assign rs2_E        = ex_q.rs2;
   assign rd_E         = ex_q.rd;
   assign ALUSrc_E     = ex_q.alu_src;
   assign RegWrite_E   = ex_q.reg_write;
   assign MemWrite_E   = ex_q.mem_write;
   assign Branch_E     = ex_q.branch;
   assign ALUControl_E = ex_q.alu_control;
   assign ResultSrc_E  = ex_q.result_src;
   assign BubbleCnt    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed hazard/flush/reset scenarios,
// randomized traffic, and counter saturation, against a rule-level model.
module tb_id_ex_reg;

   localparam int XLEN = 32;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            alu_src;
      logic            reg_write;
      logic            mem_write;
      logic            branch;
      logic [2:0]      alu_control;
      logic [1:0]      result_src;
   } ex_s;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   ex_s  din = '0;

   logic            ValidE, RegWrite_E, MemWrite_E, Branch_E, ALUSrc_E, StallF, StallD;
   logic [XLEN-1:0] PC_E, rs1_data_E, rs2_data_E, imm_ext_E;
   logic [4:0]      rs1_E, rs2_E, rd_E;
   logic [2:0]      ALUControl_E;
   logic [1:0]      ResultSrc_E;
   logic [15:0]     BubbleCnt;

   // Reference model: the EX-stage contents and the bubble tally.
   ex_s m = '0;
   int  m_cnt = 0;
   bit  cnt_forced = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_reg #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .ValidD(din.valid), .FlushE(flush),
      .PC_D(din.pc), .rs1_data_D(din.rs1_data), .rs2_data_D(din.rs2_data),
      .imm_ext_D(din.imm), .rs1_D(din.rs1), .rs2_D(din.rs2), .rd_D(din.rd),
      .ALUSrc_D(din.alu_src), .RegWrite_D(din.reg_write), .MemWrite_D(din.mem_write),
      .Branch_D(din.branch), .ALUControl_D(din.alu_control), .ResultSrc_D(din.result_src),
      .ValidE(ValidE), .PC_E(PC_E), .rs1_data_E(rs1_data_E), .rs2_data_E(rs2_data_E),
      .imm_ext_E(imm_ext_E), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
      .ALUSrc_E(ALUSrc_E), .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E),
      .Branch_E(Branch_E), .ALUControl_E(ALUControl_E), .ResultSrc_E(ResultSrc_E),
      .StallF(StallF), .StallD(StallD), .BubbleCnt(BubbleCnt)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_load_use();
      return m.valid && m.reg_write && (m.result_src == 2'b01) && (m.rd != 5'd0) &&
             ((m.rd == din.rs1) || (m.rd == din.rs2));
   endfunction

   task automatic check_state(input string tag);
      ex_s obs;
      obs = '{ValidE, PC_E, rs1_data_E, rs2_data_E, imm_ext_E, rs1_E, rs2_E, rd_E,
              ALUSrc_E, RegWrite_E, MemWrite_E, Branch_E, ALUControl_E, ResultSrc_E};
      check({tag, "_e_fields"}, 256'(obs), 256'(m));
      check({tag, "_bubble_cnt"}, 256'(BubbleCnt), 256'(m_cnt[15:0]));
   endtask

   task automatic check_stalls(input string tag, input logic exp);
      check({tag, "_stall_f"}, 256'(StallF), 256'(exp));
      check({tag, "_stall_d"}, 256'(StallD), 256'(exp));
   endtask

   // Called just after a rising edge: checks stalls for the current inputs,
   // advances the model across the next edge, then checks the registered state.
   task automatic tick(input string tag);
      logic lu;
      ex_s  nxt;
      int   nc;
      #1;
      lu = model_load_use();
      check_stalls(tag, lu && !flush);
      nc = m_cnt;
      if (flush || lu) begin
         nxt = '0;
         if (!flush && nc < 65535) nc++;
      end else begin
         nxt = din;
      end
      if (cnt_forced) nc = 16'hFFFE;
      @(posedge clk);
      m     = nxt;
      m_cnt = nc;
      #1;
      check_state(tag);
   endtask

   function automatic ex_s load_instr(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      ex_s i = '0;
      i.valid = 1'b1; i.pc = 32'h80; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
      i.reg_write = 1'b1; i.result_src = 2'b01; i.alu_src = 1'b1; i.imm = 32'h4;
      return i;
   endfunction

   function automatic ex_s alu_instr(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      ex_s i = '0;
      i.valid = 1'b1; i.pc = 32'h84; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
      i.reg_write = 1'b1; i.rs1_data = 32'd7; i.rs2_data = 32'd9; i.alu_control = 3'b010;
      return i;
   endfunction

   initial begin
      // Reset with garbage on the inputs: everything registered reads 0.
      din = '{1'b1, 32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3, 5'd5, 5'd5, 5'd5,
              1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 2'b01};
      #3;
      check_state("reset");
      check_stalls("reset", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      m = din;  // first edge after release was not yet seen; resync below

      // Pass-through of a plain ALU op.
      din = '0;
      din.valid = 1'b1; din.pc = 32'h100; din.rs1_data = 32'd10; din.rs2_data = 32'd5;
      din.imm = 32'd3; din.alu_control = 3'b000; din.rd = 5'd1; din.rs1 = 5'd2; din.rs2 = 5'd3;
      #1;
      m = '0;  // state captured at that edge was the reset-release garbage load with rd=5
      m = '{1'b1, 32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3, 5'd5, 5'd5, 5'd5,
            1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 2'b01};
      tick("pass_through");

      // Load-use on rs2: one stall cycle, one counted bubble, then capture.
      din = load_instr(5'd5, 5'd1, 5'd2);
      tick("load_capture");
      din = alu_instr(5'd6, 5'd4, 5'd5);
      tick("load_use_bubble");
      tick("dependent_capture");

      // Load to x0 never stalls.
      din = load_instr(5'd0, 5'd1, 5'd2);
      tick("x0_load_capture");
      din = alu_instr(5'd7, 5'd0, 5'd0);
      tick("x0_no_stall");

      // Flush wins over a simultaneous load-use.
      din = load_instr(5'd9, 5'd1, 5'd2);
      tick("flush_load_capture");
      din = alu_instr(5'd3, 5'd9, 5'd1);
      flush = 1'b1;
      tick("flush_priority");
      flush = 1'b0;
      tick("after_flush_capture");

      // Invalid ID slot propagates as a bubble with its control fields intact.
      din = alu_instr(5'd4, 5'd1, 5'd1);
      din.valid = 1'b0; din.mem_write = 1'b1; din.branch = 1'b1;
      tick("invalid_passthrough");

      // Asynchronous reset between edges.
      din = alu_instr(5'd8, 5'd1, 5'd2);
      din.pc = 32'h200;
      tick("pre_async_reset");
      #2;
      rst_n = 1'b0;
      m = '0; m_cnt = 0;
      #1;
      check_state("async_reset");
      check_stalls("async_reset", 1'b0);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      m = din;

      // Reset during a pending stall clears it; next edge captures normally.
      din = load_instr(5'd12, 5'd1, 5'd2);
      tick("stall_load_capture");
      din = alu_instr(5'd13, 5'd12, 5'd3);
      #1;
      check_stalls("pre_reset_stall", 1'b1);
      rst_n = 1'b0;
      m = '0; m_cnt = 0;
      #1;
      check_stalls("mid_stall_reset", 1'b0);
      check_state("mid_stall_reset");
      #2;
      rst_n = 1'b1;
      tick("post_reset_capture");

      // Randomized traffic with small register indices to provoke hazards.
      for (int i = 0; i < 300; i++) begin
         din.valid       = ($urandom_range(0, 3) != 0);
         din.pc          = $urandom;
         din.rs1_data    = $urandom;
         din.rs2_data    = $urandom;
         din.imm         = $urandom;
         din.rs1         = 5'($urandom_range(0, 3));
         din.rs2         = 5'($urandom_range(0, 3));
         din.rd          = 5'($urandom_range(0, 3));
         din.alu_src     = 1'($urandom);
         din.reg_write   = 1'($urandom);
         din.mem_write   = 1'($urandom);
         din.branch      = 1'($urandom);
         din.alu_control = 3'($urandom);
         din.result_src  = 2'($urandom);
         flush           = ($urandom_range(0, 7) == 0);
         tick("random");
      end
      flush = 1'b0;

      // Saturation: preset the counter near its ceiling, then add bubbles.
      din = load_instr(5'd7, 5'd1, 5'd2);
      force dut.bubble_cnt_d = 16'hFFFE;
      cnt_forced = 1'b1;
      tick("sat_preset");
      release dut.bubble_cnt_d;
      cnt_forced = 1'b0;
      din = alu_instr(5'd3, 5'd7, 5'd2);
      tick("sat_reach_max");
      din = load_instr(5'd7, 5'd1, 5'd2);
      tick("sat_load_capture");
      din = alu_instr(5'd3, 5'd1, 5'd7);
      tick("sat_hold_max");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter XLEN, default 32, sets the datapath width of all data fields.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ValidD  input  1  the ID-stage instruction is real, not a bubble.
REQ-005 FlushE  input  1  from EX branch resolution; kills the instruction entering EX.
REQ-006 PC_D, rs1_data_D, rs2_data_D, imm_ext_D  input  XLEN each  decoded operands from ID.
REQ-007 rs1_D, rs2_D, rd_D  input  5 each  register indices from ID.
REQ-008 ALUSrc_D, RegWrite_D, MemWrite_D, Branch_D  input  1 each  control bits.
REQ-009 ALUControl_D  input  3  ALU op; ResultSrc_D  input  2  (2'b01 = load).
REQ-010 Every *_D input SHALL have a matching registered *_E output of identical width.
REQ-011 ValidE  output  1  the EX-stage instruction is real.
REQ-012 StallF, StallD  output  1 each  hold PC and IF/ID (load-use hazard).
REQ-013 BubbleCnt  output  16  saturating count of load-use bubbles inserted.

Function
REQ-014 All *_E outputs SHALL update only on the rising edge of clk, 1-cycle latency D->E.
REQ-015 LoadUse SHALL be combinational from registered state: ValidE & RegWrite_E & ResultSrc_E==2'b01 & rd_E!=0 & (rd_E==rs1_D | rd_E==rs2_D).
REQ-016 rd_E==0 SHALL never raise LoadUse.
REQ-017 StallF = StallD = LoadUse & ~FlushE, combinational.
REQ-018 Edge with FlushE=1: insert bubble, regardless of LoadUse (flush has priority).
REQ-019 Edge with FlushE=0, LoadUse=1: insert bubble; ID contents are not consumed (upstream held by StallD).
REQ-020 Edge with FlushE=0, LoadUse=0: capture every *_D into *_E; ValidE <= ValidD.
REQ-021 Bubble: ValidE, RegWrite_E, MemWrite_E, Branch_E, ALUSrc_E <= 0; ALUControl_E <= 3'b000; ResultSrc_E <= 2'b00; rd_E, rs1_E, rs2_E <= 0; PC_E, rs1_data_E, rs2_data_E, imm_ext_E <= 0.
REQ-022 After a load-use bubble, LoadUse SHALL drop next cycle (ValidE=0), so a single load causes exactly one stall cycle.
REQ-023 BubbleCnt SHALL increment by 1 on each edge taking REQ-019, not on flush bubbles, saturating at 16'hFFFF.
REQ-024 Simultaneous FlushE and LoadUse: one flush bubble, BubbleCnt unchanged, StallF/StallD=0.
REQ-025 ValidD=0 with no flush/stall SHALL propagate as a bubble with control fields captured as presented (ValidE=0 gates downstream).

Reset
REQ-026 rst_n low SHALL immediately, without a clock, force every *_E output, ValidE and BubbleCnt to 0.
REQ-027 During and right after reset StallF=StallD=0 (ValidE=0).
REQ-028 Reset asserted mid-stall SHALL clear the pending bubble; first edge after release captures D normally.

Verification
REQ-029 Pass-through: ValidD=1, PC_D=32'h100, rs1_data_D=10, rs2_data_D=5, imm_ext_D=3, ALUControl_D=000, one edge -> identical *_E values, ValidE=1, stalls 0.
REQ-030 Load-use: load in E (ResultSrc_E=01, RegWrite_E=1, rd_E=5), ID rs2_D=5 -> StallF=StallD=1, next edge bubble (ValidE=0, RegWrite_E=0), BubbleCnt=1, next cycle stalls 0 and dependent instruction captured.
REQ-031 x0 load: rd_E=0, rs1_D=0 -> StallD=0, normal capture, BubbleCnt unchanged.
REQ-032 Flush priority: FlushE=1 with LoadUse=1 -> bubble, StallD=0, BubbleCnt unchanged.
REQ-033 Async reset: rst_n low between edges with ValidE=1, PC_E=32'h200 -> all outputs 0 before next edge.
REQ-034 Saturation: preload 65535 load-use bubbles (or force) -> BubbleCnt holds 16'hFFFF on further bubble.
